// File: rtl/carregador_de_instrucoes.sv
// Boot loader: parses a 16-bit big-endian word-count header, assembles big-endian
// 32-bit instructions from a byte stream and writes them into instruction memory.
module carregador_de_instrucoes #(
    parameter int unsigned RAM_SIZE  = 500,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_datain,
    output logic                 cpu_halt,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state_q;
    logic [7:0]           len_hi_q;
    logic [CNT_WIDTH-1:0] length_q;
    logic [1:0]           bcnt_q;
    logic [23:0]          word_q;

    logic                 byte_ready_q;
    logic                 mem_we_q;
    logic [31:0]          mem_addr_q;
    logic [31:0]          mem_datain_q;
    logic                 cpu_halt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic [CNT_WIDTH-1:0] words_q;

    logic                 xfer;
    logic [15:0]          hdr_d;
    logic [31:0]          word_d;
    logic [CNT_WIDTH-1:0] words_d;

    assign xfer    = byte_valid & byte_ready_q;
    assign hdr_d   = {len_hi_q, byte_in};
    assign word_d  = {word_q, byte_in};
    assign words_d = words_q + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_hi_q     <= 8'd0;
            length_q     <= '0;
            bcnt_q       <= 2'd0;
            word_q       <= 24'd0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'(BASE_ADDR);
            mem_datain_q <= 32'd0;
            cpu_halt_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q      <= S_LEN_HI;
                        words_q      <= '0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        mem_addr_q   <= 32'(BASE_ADDR);
                        cpu_halt_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        byte_ready_q <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_hi_q <= byte_in;
                        state_q  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        length_q <= CNT_WIDTH'(hdr_d);
                        if (hdr_d == 16'd0) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            cpu_halt_q   <= 1'b0;
                            byte_ready_q <= 1'b0;
                        end else if (32'(hdr_d) > RAM_SIZE) begin
                            // Oversized program: refuse it before any memory write.
                            state_q      <= S_ERROR;
                            error_q      <= 1'b1;
                            busy_q       <= 1'b0;
                            cpu_halt_q   <= 1'b1;
                            byte_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_RECV;
                            bcnt_q  <= 2'd0;
                        end
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        word_q <= word_d[23:0];
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            mem_datain_q <= word_d;
                            mem_we_q     <= 1'b1;
                            byte_ready_q <= 1'b0;
                            state_q      <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    mem_addr_q <= mem_addr_q + 32'd1;
                    words_q    <= words_d;
                    if (words_d == length_q) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cpu_halt_q <= 1'b0;
                    end else begin
                        state_q      <= S_RECV;
                        byte_ready_q <= 1'b1;
                        bcnt_q       <= 2'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready   = byte_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_datain   = mem_datain_q;
    assign cpu_halt     = cpu_halt_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule
